tm_cpu_token_tx: RTL and testbench

CPU-side transmitter of the timing-model token channel. It is the opposite end of the path feeding `tm_cpu_l1`. It receives per-thread advance grants from the timing model and keeps a credit count for each thread. It walks the interleaved thread slots round-robin and, for each slot, emits one control token toward the timing model through a fixed-depth output pipeline. For each slot it also tells the functional pipeline whether the thread may commit or must replay.

---
 rtl/tm_cpu_token_tx_pkg.sv | 58 +++++
 rtl/tm_token_delay.sv | 35 +++
 rtl/tm_cpu_token_tx.sv | 159 +++++++++++++++
 tb/tb_tm_cpu_token_tx.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tm_cpu_token_tx_pkg.sv
// Shared types and sizes for the CPU-side timing-model token transmitter.
package tm_cpu_token_tx_pkg;

  localparam int unsigned NTHREAD      = 8;
  localparam int unsigned NTHREADIDMSB = 2;
  localparam int unsigned TID_W        = NTHREADIDMSB + 1;
  localparam int unsigned CNT_W        = 32;

  typedef logic [NTHREADIDMSB:0] tid_t;

  typedef struct packed {
    logic clk;
  } iu_clk_type;

  typedef struct packed {
    logic tm_dbg_start;
    logic tm_dbg_stop;
    logic tm_dbg_nop;
  } tm_dbg_ctrl_type;

  typedef struct packed {
    tid_t            threads_total;
    tid_t            threads_active;
    tm_dbg_ctrl_type tm_dbg_ctrl;
  } dma_tm_ctrl_type;

  // Advance grant from the timing model
  typedef struct packed {
    logic valid;
    tid_t tid;
    logic run;
  } tm2cpu_token_type;

  // Functional-pipeline event for the current slot
  typedef struct packed {
    logic valid;
    tid_t tid;
    logic ldst;
    logic icmiss;
    logic dcmiss;
  } cpu_tm_evt_type;

  // Control token sent toward the timing model
  typedef struct packed {
    logic valid;
    tid_t tid;
    logic run;
    logic ldst;
    logic icmiss;
    logic dcmiss;
  } tm_cpu_ctrl_token_type;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } run_state_e;

endpackage

// File: rtl/tm_token_delay.sv
// Fixed-depth token shift register; reset clears every stage.
module tm_token_delay
  import tm_cpu_token_tx_pkg::*;
#(
  parameter int unsigned STAGES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  tm_cpu_ctrl_token_type tok_in,
  output tm_cpu_ctrl_token_type tok_out
);

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    tm_cpu_ctrl_token_type stage_in;
    tm_cpu_ctrl_token_type q;

    if (g == 0) begin : g_first
      assign stage_in = tok_in;
    end else begin : g_rest
      assign stage_in = g_stage[g-1].q;
    end

    // One pipeline stage; in-flight tokens are discarded on reset
    always_ff @(posedge clk) begin
      if (rst) begin
        q <= '0;
      end else begin
        q <= stage_in;
      end
    end
  end

  assign tok_out = g_stage[STAGES-1].q;

endmodule

// File: rtl/tm_cpu_token_tx.sv
// CPU-side token transmitter: per-thread credits, round-robin slot walk,
// commit/replay decision and delayed control-token emission.
module tm_cpu_token_tx
  import tm_cpu_token_tx_pkg::*;
#(
  parameter int unsigned OUT_STAGES  = 8,
  parameter int unsigned CREDIT_MAX  = 3,
  parameter int unsigned INIT_CREDIT = 1
) (
  input  iu_clk_type            gclk,
  input  logic                  rst,
  input  dma_tm_ctrl_type       dma2tm,
  input  tm2cpu_token_type      tm2cpu,
  input  cpu_tm_evt_type        cpu_in,
  output tm_cpu_ctrl_token_type cpu2tm,
  output logic                  cpu_replay,
  output tid_t                  slot_tid,
  output logic                  seq_err,
  output logic [CNT_W-1:0]      tok_cnt,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam int unsigned CRED_W = $clog2(CREDIT_MAX + 1);

  logic clk;
  assign clk = gclk.clk;

  // No defined behaviour for the nop control bit
  logic unused_nop;
  assign unused_nop = dma2tm.tm_dbg_ctrl.tm_dbg_nop;

  run_state_e            state_q, state_d;
  logic                  load_credits;
  logic                  running;
  logic                  slot_active;
  logic                  has_credit;
  logic                  issue;
  logic                  grant_ok;
  logic [CRED_W-1:0]     credit_q [NTHREAD];
  tm_cpu_ctrl_token_type dec_tok;

  // Run-state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Start only from idle (reloads credits); stop returns to idle
  always_comb begin
    state_d      = state_q;
    load_credits = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (dma2tm.tm_dbg_ctrl.tm_dbg_start) begin
          state_d      = ST_RUN;
          load_credits = 1'b1;
        end
      end
      ST_RUN: begin
        if (dma2tm.tm_dbg_ctrl.tm_dbg_stop) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  assign running     = (state_q == ST_RUN);
  assign slot_active = running && (slot_tid <= dma2tm.threads_active);
  assign has_credit  = (credit_q[slot_tid] != '0);
  assign issue       = slot_active && has_credit;
  assign cpu_replay  = slot_active && !has_credit;
  assign grant_ok    = tm2cpu.valid && tm2cpu.run;

  // Slot walker: wraps after threads_total, frozen while idle
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_tid <= '0;
    end else if (running) begin
      slot_tid <= (slot_tid >= dma2tm.threads_total) ? '0 : slot_tid + TID_W'(1);
    end
  end

  // Per-thread credit flops: grant writer and issue writer cancel when both hit
  for (genvar g = 0; g < NTHREAD; g++) begin : g_cred
    localparam tid_t TID = TID_W'(g);
    logic [CRED_W-1:0] cnt_q;
    logic              inc;
    logic              dec;

    assign inc = grant_ok && (tm2cpu.tid == TID);
    assign dec = issue && (slot_tid == TID);

    // Credit counter with saturating increment
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else if (load_credits) begin
        cnt_q <= (TID <= dma2tm.threads_active) ? CRED_W'(INIT_CREDIT) : '0;
      end else if (inc && !dec) begin
        if (cnt_q != CRED_W'(CREDIT_MAX)) begin
          cnt_q <= cnt_q + CRED_W'(1);
        end
      end else if (dec && !inc) begin
        cnt_q <= cnt_q - CRED_W'(1);
      end
    end

    assign credit_q[g] = cnt_q;
  end

  // Slot decision token; flags travel only on committed (run=1) tokens
  always_comb begin
    dec_tok = '0;
    if (slot_active) begin
      dec_tok.valid = 1'b1;
      dec_tok.tid   = slot_tid;
      if (has_credit) begin
        dec_tok.run = 1'b1;
        if (cpu_in.valid) begin
          dec_tok.ldst   = cpu_in.ldst;
          dec_tok.icmiss = cpu_in.icmiss;
          dec_tok.dcmiss = cpu_in.dcmiss;
        end
      end
    end
  end

  // Issue/stall counters and sticky slot-sequence error
  always_ff @(posedge clk) begin
    if (rst) begin
      tok_cnt   <= '0;
      stall_cnt <= '0;
      seq_err   <= 1'b0;
    end else begin
      if (issue) begin
        tok_cnt <= tok_cnt + CNT_W'(1);
      end
      if (cpu_replay) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (cpu_in.valid && (cpu_in.tid != slot_tid)) begin
        seq_err <= 1'b1;
      end
    end
  end

  tm_token_delay #(
    .STAGES (OUT_STAGES)
  ) u_delay (
    .clk     (clk),
    .rst     (rst),
    .tok_in  (dec_tok),
    .tok_out (cpu2tm)
  );

endmodule

// File: tb/tb_tm_cpu_token_tx.sv
// Directed bench for tm_cpu_token_tx.
module tb_tm_cpu_token_tx;
  import tm_cpu_token_tx_pkg::*;

  iu_clk_type            gclk;
  logic                  rst;
  dma_tm_ctrl_type       dma2tm;
  tm2cpu_token_type      tm2cpu;
  cpu_tm_evt_type        cpu_in;
  tm_cpu_ctrl_token_type cpu2tm;
  logic                  cpu_replay;
  tid_t                  slot_tid;
  logic                  seq_err;
  logic [31:0]           tok_cnt;
  logic [31:0]           stall_cnt;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  tm_cpu_token_tx #(
    .OUT_STAGES  (8),
    .CREDIT_MAX  (3),
    .INIT_CREDIT (1)
  ) dut (
    .gclk       (gclk),
    .rst        (rst),
    .dma2tm     (dma2tm),
    .tm2cpu     (tm2cpu),
    .cpu_in     (cpu_in),
    .cpu2tm     (cpu2tm),
    .cpu_replay (cpu_replay),
    .slot_tid   (slot_tid),
    .seq_err    (seq_err),
    .tok_cnt    (tok_cnt),
    .stall_cnt  (stall_cnt)
  );

  initial begin
    gclk.clk = 1'b0;
    forever #5 gclk.clk = ~gclk.clk;
  end

  function automatic tm_cpu_ctrl_token_type mk_tok(input logic v, input tid_t t, input logic r,
                                                    input logic l, input logic i, input logic d);
    tm_cpu_ctrl_token_type x;
    x.valid  = v;
    x.tid    = t;
    x.run    = r;
    x.ldst   = l;
    x.icmiss = i;
    x.dcmiss = d;
    return x;
  endfunction

  task automatic tick();
    @(posedge gclk.clk);
    #1;
    cyc++;
  endtask

  task automatic go(input int c);
    while (cyc < c) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s @cyc%0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic grant(input tid_t t);
    tm2cpu.valid = 1'b1;
    tm2cpu.tid   = t;
    tm2cpu.run   = 1'b1;
  endtask

  task automatic nogrant();
    tm2cpu = '0;
  endtask

  initial begin
    rst    = 1'b1;
    dma2tm = '0;
    tm2cpu = '0;
    cpu_in = '0;
    tick();
    tick();

    // reset state
    chk("rst_cpu2tm", 32'(cpu2tm), 32'd0);
    chk("rst_replay", 32'(cpu_replay), 32'd0);
    chk("rst_slot", 32'(slot_tid), 32'd0);
    chk("rst_seq_err", 32'(seq_err), 32'd0);
    chk("rst_tok_cnt", tok_cnt, 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);

    // start with 4 active threads
    rst = 1'b0;
    dma2tm.threads_total  = 3'd3;
    dma2tm.threads_active = 3'd3;
    dma2tm.tm_dbg_ctrl.tm_dbg_start = 1'b1;
    tick();
    dma2tm.tm_dbg_ctrl.tm_dbg_start = 1'b0;
    cyc = 0;

    // lap 1 all run=1, later laps run=0; output lags decisions by 8
    for (int j = 0; j < 16; j++) begin
      chk("l1_slot", 32'(slot_tid), 32'(j % 4));
      chk("l1_replay", 32'(cpu_replay), 32'(j >= 4));
      if (j >= 8) chk("l1_cpu2tm", 32'(cpu2tm), 32'(mk_tok(1'b1, 3'((j - 8) % 4), j < 12, 1'b0, 1'b0, 1'b0)));
      else        chk("l1_empty", 32'(cpu2tm), 32'd0);
      tick();
    end
    chk("l1_tok_cnt", tok_cnt, 32'd4);
    chk("l1_stall_cnt", stall_cnt, 32'd12);

    // grant and issue on the same cycle for tid 2
    grant(3'd2);
    tick();
    nogrant();
    chk("g2_slot1", 32'(slot_tid), 32'd1);
    chk("g2_replay1", 32'(cpu_replay), 32'd1);
    tick();
    chk("g2_slot2", 32'(slot_tid), 32'd2);
    chk("g2_issue_a", 32'(cpu_replay), 32'd0);
    grant(3'd2);
    tick();
    nogrant();
    go(22);
    chk("g2_issue_b", 32'(cpu_replay), 32'd0);
    cpu_in = '{valid: 1'b1, tid: 3'd2, ldst: 1'b1, icmiss: 1'b0, dcmiss: 1'b1};
    tick();
    cpu_in = '0;
    go(26);
    chk("g2_drained", 32'(cpu_replay), 32'd1);
    chk("g2_tok_c18", 32'(cpu2tm), 32'(mk_tok(1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0)));
    cpu_in = '{valid: 1'b1, tid: 3'd2, ldst: 1'b1, icmiss: 1'b1, dcmiss: 1'b1};
    tick();
    cpu_in = '0;
    go(30);
    chk("flags_run", 32'(cpu2tm), 32'(mk_tok(1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1)));
    go(34);
    chk("flags_replay", 32'(cpu2tm), 32'(mk_tok(1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0)));
    chk("g2_tok_cnt", tok_cnt, 32'd6);
    chk("g2_stall_cnt", stall_cnt, 32'd28);
    chk("g2_seq_err", 32'(seq_err), 32'd0);

    // 8-slot lap, 5 grants to tid 0 away from its slot: saturates at 3
    dma2tm.threads_total = 3'd7;
    go(40);
    chk("sat_slot0", 32'(slot_tid), 32'd0);
    chk("sat_pre", 32'(cpu_replay), 32'd1);
    go(41);
    grant(3'd0);
    go(44);
    chk("inactive_tok", 32'(cpu2tm), 32'd0);
    go(46);
    nogrant();
    go(48);
    chk("sat_run1", 32'(cpu_replay), 32'd0);
    go(56);
    chk("sat_run2", 32'(cpu_replay), 32'd0);
    chk("sat_tok", 32'(cpu2tm), 32'(mk_tok(1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0)));
    go(64);
    chk("sat_run3", 32'(cpu_replay), 32'd0);
    go(72);
    chk("sat_slot", 32'(slot_tid), 32'd0);
    chk("sat_empty", 32'(cpu_replay), 32'd1);
    go(73);
    chk("sat_tok_cnt", tok_cnt, 32'd9);

    // stop mid-lap: in-flight tokens drain, slot freezes
    dma2tm.tm_dbg_ctrl.tm_dbg_stop = 1'b1;
    tick();
    dma2tm.tm_dbg_ctrl.tm_dbg_stop = 1'b0;
    chk("stop_slot", 32'(slot_tid), 32'd2);
    chk("stop_replay", 32'(cpu_replay), 32'd0);
    go(80);
    chk("stop_hold", 32'(slot_tid), 32'd2);
    go(81);
    chk("drain_last", 32'(cpu2tm), 32'(mk_tok(1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0)));
    go(82);
    chk("drain_done", 32'(cpu2tm), 32'd0);

    // restart with 2 of 4 threads active
    dma2tm.threads_total  = 3'd3;
    dma2tm.threads_active = 3'd1;
    dma2tm.tm_dbg_ctrl.tm_dbg_start = 1'b1;
    tick();
    dma2tm.tm_dbg_ctrl.tm_dbg_start = 1'b0;
    chk("act_slot2", 32'(slot_tid), 32'd2);
    chk("act_inact_rep", 32'(cpu_replay), 32'd0);
    go(87);
    chk("act_tok_lap1", tok_cnt, 32'd11);
    grant(3'd0);
    tick();
    grant(3'd1);
    tick();
    nogrant();
    chk("act_slot0", 32'(slot_tid), 32'd0);
    chk("act_run0", 32'(cpu_replay), 32'd0);
    tick();
    chk("act_run1", 32'(cpu_replay), 32'd0);
    tick();
    chk("act_tok_lap2", tok_cnt, 32'd13);
    chk("act_inact_tok2", 32'(cpu2tm), 32'd0);
    dma2tm.tm_dbg_ctrl.tm_dbg_start = 1'b1;
    tick();
    dma2tm.tm_dbg_ctrl.tm_dbg_start = 1'b0;
    chk("act_inact_tok3", 32'(cpu2tm), 32'd0);
    tick();
    chk("restart_ignored", 32'(cpu_replay), 32'd1);
    chk("act_tok0", 32'(cpu2tm), 32'(mk_tok(1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0)));
    grant(3'd1);
    tick();
    nogrant();

    // wrong-tid event during slot 1
    chk("seq_slot1", 32'(slot_tid), 32'd1);
    chk("seq_issue", 32'(cpu_replay), 32'd0);
    chk("seq_pre", 32'(seq_err), 32'd0);
    cpu_in = '{valid: 1'b1, tid: 3'd5, ldst: 1'b1, icmiss: 1'b1, dcmiss: 1'b0};
    tick();
    cpu_in = '0;
    chk("seq_set", 32'(seq_err), 32'd1);
    chk("seq_tok_cnt", tok_cnt, 32'd14);
    go(100);
    chk("seq_sticky", 32'(seq_err), 32'd1);
    go(102);
    chk("seq_tok", 32'(cpu2tm), 32'(mk_tok(1'b1, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0)));

    // reset while tokens are in flight
    go(104);
    rst = 1'b1;
    tick();
    chk("mrst_cpu2tm", 32'(cpu2tm), 32'd0);
    chk("mrst_seq_err", 32'(seq_err), 32'd0);
    chk("mrst_tok_cnt", tok_cnt, 32'd0);
    chk("mrst_slot", 32'(slot_tid), 32'd0);
    chk("mrst_replay", 32'(cpu_replay), 32'd0);
    rst = 1'b0;
    tick();
    chk("post_cpu2tm", 32'(cpu2tm), 32'd0);
    chk("post_stall", stall_cnt, 32'd0);
    chk("post_slot", 32'(slot_tid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
